ippro_flag_pipe: RTL and testbench
==================================

# ippro_flag_pipe

Registered, latency-aligned flag unit for the IPPro datapath, replacing the level-sensitive flag logic. It delays the instruction's flag-update enable to line up with the pipelined ALU/DSP result, then captures Z/EQ/GT/S flags into registers. It also evaluates a selected branch/select condition and keeps sticky zero/sign status plus a saturating zero-result counter for per-frame statistics. It sits between the ALU output stage and the core's conditional-execution/select logic.

## Interface
- DATA_W, 16, ALU result width.
- EN_LAT, 2, cycles from ENABLE issue to matching ALU_OUT/PATTERNDETECT validity; legal 0..7.
- CNT_W, 16, width of the zero-result counter.

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  reset, synchronous, active-high.
- PAUSE  in  1  pipeline stall; freezes all state.
- ENABLE  in  1  flag-update request, issued with the instruction.
- ALU_OUT  in  DATA_W  ALU result, two's complement.
- PATTERNDETECT  in  1  DSP equality detect, aligned with ALU_OUT.
- COND_SEL  in  3  condition select for COND_OUT.
- CLR_STICKY  in  1  clears sticky flags and ZCOUNT.
- ZF, EQF, GTF, SF  out  1 each  registered flags.
- NZF, NEQF, NGTF, NSF  out  1 each  complements of the registered flags.
- COND_OUT  out  1  selected condition.
- FLAG_VALID  out  1  flags updated at the last edge.
- STICKY_ZF, STICKY_SF  out  1 each  zero/negative seen since clear.
- ZCOUNT  out  CNT_W  zero results since clear, saturating.

## Operation
- Enable alignment:
  - ENABLE enters an EN_LAT-deep shift register that advances only when PAUSE=0.
  - Its output en_d is the capture qualifier.
  - With EN_LAT=0, en_d = ENABLE and there is no register.
- Capture occurs at an edge where RESET=0, PAUSE=0 and en_d=1. At capture:
  - ZF <= (ALU_OUT == 0).
  - EQF <= PATTERNDETECT.
  - SF <= ALU_OUT[DATA_W-1].
  - GTF <= ~ALU_OUT[DATA_W-1] & (ALU_OUT != 0), i.e. strictly positive result.
- Non-capture edge: flags hold their value.
- N* outputs are the combinational inverse of the registered flags.
- COND_OUT is combinational from the registered flags, selected by COND_SEL:
  - 0: 1 (always)
  - 1: ZF
  - 2: NZF
  - 3: EQF
  - 4: NEQF
  - 5: GTF
  - 6: NGTF
  - 7: SF
- Sticky status:
  - At capture, STICKY_ZF |= zero result and STICKY_SF |= sign bit.
  - ZCOUNT increments on a zero-result capture and saturates at 2^CNT_W-1; it never wraps.
- CLR_STICKY (when PAUSE=0):
  - Clears STICKY_ZF, STICKY_SF and ZCOUNT.
  - If a capture happens at the same edge, the new event wins: the sticky bit is set from the new result and ZCOUNT becomes 1 on a zero result, otherwise 0.
- FLAG_VALID <= capture at every non-paused edge. It is forced to 0 on a paused edge.
- PAUSE=1 holds everything, including in-flight enables in the shift register; CLR_STICKY is ignored.
- RESET priority is RESET > PAUSE > capture/clear. RESET clears the enable shift register and all outputs.
- RESET mid-operation drops every in-flight enable; results arriving after reset never update flags.

## Timing
- Reset values:
  - ZF, EQF, GTF, SF, FLAG_VALID, STICKY_ZF, STICKY_SF = 0.
  - ZCOUNT = 0.
  - NZF, NEQF, NGTF, NSF = 1.
  - COND_OUT = 1 when COND_SEL selects 0, 2, 4 or 6; otherwise 0.
- ENABLE sampled at edge k (no PAUSE) gives capture at edge k+EN_LAT.
  - The flags and FLAG_VALID are visible after edge k+EN_LAT.
  - ALU_OUT/PATTERNDETECT must be valid in the cycle preceding that edge.
- Each paused edge between issue and capture adds exactly one cycle of latency.
- Back-to-back ENABLEs produce back-to-back captures; throughput is 1 per cycle and FLAG_VALID stays high continuously.
- COND_OUT has zero latency from COND_SEL and from the flag registers.

## Test plan
- Reset and basic capture:
  - Stimulus: assert RESET 2 cycles with EN_LAT=2, then ENABLE at cycle 0 with ALU_OUT=0x0000 and PATTERNDETECT=1 present before edge 2.
  - Required: after edge 2, ZF=1, EQF=1, GTF=0, SF=0, FLAG_VALID=1 for one cycle, ZCOUNT=1, STICKY_ZF=1.
- Sign and greater-than:
  - Stimulus: consecutive ENABLEs with ALU_OUT=0x8000, 0x0005, 0xFFFF.
  - Required: successive (SF,GTF,ZF) = (1,0,0), (0,1,0), (1,0,0); FLAG_VALID held high for 3 cycles; STICKY_SF=1.
- PAUSE in flight:
  - Stimulus: ENABLE at cycle 0, PAUSE high for cycles 1–3, ALU_OUT=0 held.
  - Required: capture at edge 5 rather than edge 2; FLAG_VALID=0 during the pause; flags unchanged until edge 5.
- Condition select:
  - Stimulus: after capturing ALU_OUT=0x0003, sweep COND_SEL 0–7.
  - Required: COND_OUT = 1,0,1,EQF,~EQF,1,0,0.
- Saturation and clear collision:
  - Stimulus: CNT_W=2; capture 5 zero results; then CLR_STICKY in the same cycle as a zero-result capture.
  - Required: ZCOUNT sequence 1,2,3,3,3, then 1 after the collision edge; STICKY_ZF stays 1.
- Reset mid-flight:
  - Stimulus: ENABLE at cycle 0 with EN_LAT=3, RESET at cycle 1.
  - Required: no capture at edge 3; FLAG_VALID stays 0 and all flags stay at reset values.

Source files
------------

// File: rtl/ippro_flag_pipe_if.sv
// Datapath-side bundle for the IPPro flag unit: stall, flag-update request, ALU result
// and condition select in; registered flags, condition and frame statistics out.
interface ippro_flag_pipe_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16
);
  logic              PAUSE;
  logic              ENABLE;
  logic [DATA_W-1:0] ALU_OUT;
  logic              PATTERNDETECT;
  logic [2:0]        COND_SEL;
  logic              CLR_STICKY;

  logic              ZF;
  logic              EQF;
  logic              GTF;
  logic              SF;
  logic              NZF;
  logic              NEQF;
  logic              NGTF;
  logic              NSF;
  logic              COND_OUT;
  logic              FLAG_VALID;
  logic              STICKY_ZF;
  logic              STICKY_SF;
  logic [CNT_W-1:0]  ZCOUNT;

  modport master (
    output PAUSE, ENABLE, ALU_OUT, PATTERNDETECT, COND_SEL, CLR_STICKY,
    input  ZF, EQF, GTF, SF, NZF, NEQF, NGTF, NSF, COND_OUT, FLAG_VALID,
           STICKY_ZF, STICKY_SF, ZCOUNT
  );

  modport slave (
    input  PAUSE, ENABLE, ALU_OUT, PATTERNDETECT, COND_SEL, CLR_STICKY,
    output ZF, EQF, GTF, SF, NZF, NEQF, NGTF, NSF, COND_OUT, FLAG_VALID,
           STICKY_ZF, STICKY_SF, ZCOUNT
  );
endinterface

// File: rtl/ippro_flag_pipe.sv
// Latency-aligned flag unit: delays the flag-update enable to meet the pipelined ALU result,
// captures Z/EQ/GT/S, selects a branch condition and keeps sticky zero/sign status.
module ippro_flag_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned EN_LAT = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  ippro_flag_pipe_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_en_d;
  logic             w_cap;
  logic             w_zero;
  logic             w_neg;
  logic             w_cond;

  logic             r_zf;
  logic             r_eqf;
  logic             r_gtf;
  logic             r_sf;
  logic             r_flag_valid;
  logic             r_sticky_zf;
  logic             r_sticky_sf;
  logic [CNT_W-1:0] r_zcount;

  // Enable delay line; frozen on stall so in-flight requests keep their slot.
  generate
    if (EN_LAT == 0) begin : g_no_delay
      assign w_en_d = bus.ENABLE;
    end else begin : g_delay
      logic [EN_LAT-1:0] r_en_sr;
      logic [EN_LAT:0]   w_shift_in;

      assign w_shift_in = {r_en_sr, bus.ENABLE};
      assign w_en_d     = r_en_sr[EN_LAT-1];

      always_ff @(posedge CLK) begin
        if (RESET) begin
          r_en_sr <= '0;
        end else if (!bus.PAUSE) begin
          r_en_sr <= w_shift_in[EN_LAT-1:0];
        end
      end
    end
  endgenerate

  assign w_cap  = w_en_d & ~bus.PAUSE;
  assign w_zero = (bus.ALU_OUT == '0);
  assign w_neg  = bus.ALU_OUT[DATA_W-1];

  // Flag capture and frame statistics; a capture colliding with a clear wins.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_zf         <= 1'b0;
      r_eqf        <= 1'b0;
      r_gtf        <= 1'b0;
      r_sf         <= 1'b0;
      r_flag_valid <= 1'b0;
      r_sticky_zf  <= 1'b0;
      r_sticky_sf  <= 1'b0;
      r_zcount     <= '0;
    end else if (bus.PAUSE) begin
      r_flag_valid <= 1'b0;
    end else begin
      r_flag_valid <= w_cap;
      if (w_cap) begin
        r_zf  <= w_zero;
        r_eqf <= bus.PATTERNDETECT;
        r_sf  <= w_neg;
        r_gtf <= ~w_neg & ~w_zero;
      end
      if (bus.CLR_STICKY) begin
        r_sticky_zf <= w_cap & w_zero;
        r_sticky_sf <= w_cap & w_neg;
        r_zcount    <= (w_cap & w_zero) ? CNT_W'(1) : '0;
      end else if (w_cap) begin
        r_sticky_zf <= r_sticky_zf | w_zero;
        r_sticky_sf <= r_sticky_sf | w_neg;
        if (w_zero && (r_zcount != CNT_MAX)) begin
          r_zcount <= r_zcount + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_cond = 1'b1;
    case (bus.COND_SEL)
      3'd0:    w_cond = 1'b1;
      3'd1:    w_cond = r_zf;
      3'd2:    w_cond = ~r_zf;
      3'd3:    w_cond = r_eqf;
      3'd4:    w_cond = ~r_eqf;
      3'd5:    w_cond = r_gtf;
      3'd6:    w_cond = ~r_gtf;
      default: w_cond = r_sf;
    endcase
  end

  assign bus.ZF         = r_zf;
  assign bus.EQF        = r_eqf;
  assign bus.GTF        = r_gtf;
  assign bus.SF         = r_sf;
  assign bus.NZF        = ~r_zf;
  assign bus.NEQF       = ~r_eqf;
  assign bus.NGTF       = ~r_gtf;
  assign bus.NSF        = ~r_sf;
  assign bus.COND_OUT   = w_cond;
  assign bus.FLAG_VALID = r_flag_valid;
  assign bus.STICKY_ZF  = r_sticky_zf;
  assign bus.STICKY_SF  = r_sticky_sf;
  assign bus.ZCOUNT     = r_zcount;

endmodule

// File: tb/tb_ippro_flag_pipe.sv
// Bench for ippro_flag_pipe: three latency/counter-width variants driven in lockstep and
// compared every cycle against an issue-history reference model, plus directed checks.
module tb_ippro_flag_pipe;

  localparam int unsigned NI   = 3;
  localparam int unsigned HIST = 4096;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ippro_flag_pipe_if #(.DATA_W(16), .CNT_W(2))  if0 ();
  ippro_flag_pipe_if #(.DATA_W(16), .CNT_W(16)) if1 ();
  ippro_flag_pipe_if #(.DATA_W(16), .CNT_W(4))  if2 ();

  ippro_flag_pipe #(.DATA_W(16), .EN_LAT(2), .CNT_W(2))  u_dut0 (.CLK(clk), .RESET(rst), .bus(if0));
  ippro_flag_pipe #(.DATA_W(16), .EN_LAT(3), .CNT_W(16)) u_dut1 (.CLK(clk), .RESET(rst), .bus(if1));
  ippro_flag_pipe #(.DATA_W(16), .EN_LAT(0), .CNT_W(4))  u_dut2 (.CLK(clk), .RESET(rst), .bus(if2));

  int lat  [NI] = '{2, 3, 0};
  int cmax [NI] = '{3, 65535, 15};

  // Reference state: flags, statistics and the history of enables per unstalled edge.
  bit m_zf [NI], m_eqf [NI], m_gtf [NI], m_sf [NI], m_val [NI], m_sz [NI], m_ss [NI];
  int m_cnt [NI];
  int nedge [NI];
  bit ens [NI][HIST];

  int n_vec = 0;
  int n_err = 0;

  logic [28:0] obs [NI];
  assign obs[0] = {if0.ZF, if0.EQF, if0.GTF, if0.SF, if0.NZF, if0.NEQF, if0.NGTF, if0.NSF,
                   if0.COND_OUT, if0.FLAG_VALID, if0.STICKY_ZF, if0.STICKY_SF, 16'(if0.ZCOUNT)};
  assign obs[1] = {if1.ZF, if1.EQF, if1.GTF, if1.SF, if1.NZF, if1.NEQF, if1.NGTF, if1.NSF,
                   if1.COND_OUT, if1.FLAG_VALID, if1.STICKY_ZF, if1.STICKY_SF, 16'(if1.ZCOUNT)};
  assign obs[2] = {if2.ZF, if2.EQF, if2.GTF, if2.SF, if2.NZF, if2.NEQF, if2.NGTF, if2.NSF,
                   if2.COND_OUT, if2.FLAG_VALID, if2.STICKY_ZF, if2.STICKY_SF, 16'(if2.ZCOUNT)};

  function automatic bit cond_of(int i, logic [2:0] sel);
    case (sel)
      3'd0: return 1'b1;
      3'd1: return m_zf[i];
      3'd2: return !m_zf[i];
      3'd3: return m_eqf[i];
      3'd4: return !m_eqf[i];
      3'd5: return m_gtf[i];
      3'd6: return !m_gtf[i];
      default: return m_sf[i];
    endcase
  endfunction

  function automatic logic [28:0] expect_of(int i, logic [2:0] sel);
    return {m_zf[i], m_eqf[i], m_gtf[i], m_sf[i], !m_zf[i], !m_eqf[i], !m_gtf[i], !m_sf[i],
            cond_of(i, sel), m_val[i], m_sz[i], m_ss[i], 16'(m_cnt[i])};
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic model_edge(bit r, bit p, bit en, logic [15:0] alu, bit pd, bit clr);
    bit cap, z, n;
    for (int i = 0; i < int'(NI); i++) begin
      if (r) begin
        m_zf[i] = 0; m_eqf[i] = 0; m_gtf[i] = 0; m_sf[i] = 0;
        m_val[i] = 0; m_sz[i] = 0; m_ss[i] = 0; m_cnt[i] = 0; nedge[i] = 0;
      end else if (p) begin
        m_val[i] = 0;
      end else begin
        if (lat[i] == 0) cap = en;
        else             cap = (nedge[i] >= lat[i]) ? ens[i][nedge[i] - lat[i]] : 1'b0;
        ens[i][nedge[i]] = en;
        nedge[i]++;
        z = (alu == 16'h0000);
        n = alu[15];
        m_val[i] = cap;
        if (cap) begin
          m_zf[i] = z; m_eqf[i] = pd; m_sf[i] = n; m_gtf[i] = !n && !z;
        end
        if (clr) begin
          m_sz[i] = cap && z;
          m_ss[i] = cap && n;
          m_cnt[i] = (cap && z) ? 1 : 0;
        end else if (cap) begin
          m_sz[i] = m_sz[i] | z;
          m_ss[i] = m_ss[i] | n;
          if (z && m_cnt[i] < cmax[i]) m_cnt[i]++;
        end
      end
    end
  endtask

  // Drive one cycle of stimulus, advance model and DUT across one edge, compare all variants.
  task automatic step(bit r, bit p, bit en, logic [15:0] alu, bit pd, logic [2:0] sel, bit clr);
    rst = r;
    if0.PAUSE = p; if0.ENABLE = en; if0.ALU_OUT = alu; if0.PATTERNDETECT = pd;
    if0.COND_SEL = sel; if0.CLR_STICKY = clr;
    if1.PAUSE = p; if1.ENABLE = en; if1.ALU_OUT = alu; if1.PATTERNDETECT = pd;
    if1.COND_SEL = sel; if1.CLR_STICKY = clr;
    if2.PAUSE = p; if2.ENABLE = en; if2.ALU_OUT = alu; if2.PATTERNDETECT = pd;
    if2.COND_SEL = sel; if2.CLR_STICKY = clr;
    @(posedge clk);
    model_edge(r, p, en, alu, pd, clr);
    #1;
    for (int i = 0; i < int'(NI); i++) begin
      chk($sformatf("model_inst%0d", i), 32'(obs[i]), 32'(expect_of(i, sel)));
    end
  endtask

  logic [15:0] sg_alu [3] = '{16'h8000, 16'h0005, 16'hFFFF};
  logic [2:0]  sg_exp [3] = '{3'b100, 3'b010, 3'b100};
  bit          cs_exp [8] = '{1, 0, 1, 0, 1, 1, 0, 0};
  int          zc_exp [6] = '{1, 2, 3, 3, 3, 1};

  initial begin
    logic [15:0] ra;
    // Reset for two cycles
    step(1, 0, 0, 16'h0000, 0, 3'd0, 0);
    step(1, 0, 0, 16'h0000, 0, 3'd2, 0);
    chk("reset_nzf", 32'(if0.NZF), 32'd1);
    chk("reset_cond_sel2", 32'(if0.COND_OUT), 32'd1);

    // Basic capture: zero result with pattern detect lands at edge 2 on the EN_LAT=2 unit
    step(0, 0, 1, 16'h0000, 1, 3'd1, 0);
    step(0, 0, 0, 16'h0000, 1, 3'd1, 0);
    step(0, 0, 0, 16'h0000, 1, 3'd1, 0);
    chk("basic_zf_eqf_gtf_sf", 32'({if0.ZF, if0.EQF, if0.GTF, if0.SF}), 32'b1100);
    chk("basic_valid", 32'(if0.FLAG_VALID), 32'd1);
    chk("basic_zcount", 32'(if0.ZCOUNT), 32'd1);
    chk("basic_sticky_zf", 32'(if0.STICKY_ZF), 32'd1);
    step(0, 0, 0, 16'h0000, 1, 3'd1, 0);
    chk("basic_valid_one_cycle", 32'(if0.FLAG_VALID), 32'd0);

    // Sign / greater-than, back-to-back
    step(0, 0, 1, 16'h1234, 0, 3'd7, 0);
    step(0, 0, 1, 16'h1234, 0, 3'd7, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, (k == 0), sg_alu[k], 0, 3'd5, 0);
      chk($sformatf("sign_sgz_%0d", k), 32'({if0.SF, if0.GTF, if0.ZF}), 32'(sg_exp[k]));
      chk($sformatf("sign_valid_%0d", k), 32'(if0.FLAG_VALID), 32'd1);
    end
    chk("sign_sticky_sf", 32'(if0.STICKY_SF), 32'd1);
    step(0, 0, 0, 16'h0001, 0, 3'd0, 0);
    step(0, 0, 0, 16'h0001, 0, 3'd0, 0);

    // Stall while a request is in flight
    step(0, 0, 1, 16'h0000, 0, 3'd1, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 16'h0000, 0, 3'd1, 0);
      chk($sformatf("pause_valid_%0d", k), 32'(if0.FLAG_VALID), 32'd0);
    end
    step(0, 0, 0, 16'h0000, 0, 3'd1, 0);
    chk("pause_not_early", 32'(if0.FLAG_VALID), 32'd0);
    step(0, 0, 0, 16'h0000, 0, 3'd1, 0);
    chk("pause_capture_edge5", 32'({if0.FLAG_VALID, if0.ZF}), 32'b11);
    step(0, 0, 0, 16'h0000, 0, 3'd1, 0);

    // Condition select sweep after capturing +3
    for (int k = 0; k < 3; k++) step(0, 0, (k == 0), 16'h0003, 0, 3'd0, 0);
    step(0, 0, 0, 16'h0003, 0, 3'd0, 0);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 0, 16'h0003, 0, 3'(k), 0);
      chk($sformatf("cond_sel_%0d", k), 32'(if0.COND_OUT), 32'(cs_exp[k]));
    end

    // Counter saturation, then clear colliding with a zero capture
    step(0, 0, 0, 16'h0000, 0, 3'd0, 1);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, (k < 6), 16'h0000, 0, 3'd1, (k == 7));
      if (k >= 2) begin
        chk($sformatf("zcount_%0d", k), 32'(if0.ZCOUNT), 32'(zc_exp[k-2]));
        chk($sformatf("zsticky_%0d", k), 32'(if0.STICKY_ZF), 32'd1);
      end
    end
    step(0, 0, 0, 16'h0000, 0, 3'd1, 0);

    // Reset while a request is in flight on the EN_LAT=3 unit
    step(0, 0, 1, 16'h0000, 1, 3'd0, 0);
    step(1, 0, 0, 16'h0000, 1, 3'd0, 0);
    step(0, 0, 0, 16'h0000, 1, 3'd0, 0);
    step(0, 0, 0, 16'h0000, 1, 3'd0, 0);
    chk("rstmid_no_capture", 32'({if1.FLAG_VALID, if1.ZF, if1.EQF, if1.ZCOUNT}), 32'd0);
    step(0, 0, 0, 16'h0000, 1, 3'd0, 0);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      case ($urandom_range(0, 3))
        0:       ra = 16'h0000;
        1:       ra = 16'h8000 | 16'($urandom);
        2:       ra = 16'($urandom);
        default: ra = 16'($urandom_range(0, 3));
      endcase
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0), 1'($urandom),
           ra, 1'($urandom), 3'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
